// File: rtl/regfile_write_arbiter.sv
// Two-source register-file write arbiter (ALU priority, MEM anti-starvation); 1-cycle write latency.
// Backpressure: combinational one-hot ready; a denied source holds until granted.
module regfile_write_arbiter #(
  parameter int STARVE_LIMIT       = 3,
  parameter int REGISTER_FILE_SIZE = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        alu_valid,
  input  logic [5:0]  alu_id,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [5:0]  mem_id,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        write_en,
  output logic [5:0]  write_id,
  output logic [31:0] write_data,
  input  logic [5:0]  byp_id,
  output logic        byp_hit,
  output logic [31:0] byp_data
);

  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [6:0] RF_SIZE = 7'(REGISTER_FILE_SIZE);

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        write_en_q, write_en_d;
  logic [5:0]  write_id_q, write_id_d;
  logic [31:0] write_data_q, write_data_d;

  logic        starve;
  logic        alu_xfer, mem_xfer;
  logic [5:0]  sel_id;
  logic [31:0] sel_data;
  logic        sel_legal;

  // Ready is gated by reset so both handshakes are dead while reset is held.
  always_comb begin
    starve    = (starve_cnt_q == LIMIT);
    alu_ready = reset_n & alu_valid & ~starve;
    mem_ready = reset_n & mem_valid & (starve | ~alu_valid);
    alu_xfer  = alu_valid & alu_ready;
    mem_xfer  = mem_valid & mem_ready;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!mem_valid || mem_xfer) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // x0 and out-of-range ids are accepted but never reach the write port.
  always_comb begin
    sel_id       = mem_xfer ? mem_id   : alu_id;
    sel_data     = mem_xfer ? mem_data : alu_data;
    sel_legal    = (sel_id != 6'd0) && ({1'b0, sel_id} < RF_SIZE);
    write_en_d   = (alu_xfer | mem_xfer) & sel_legal;
    write_id_d   = write_id_q;
    write_data_d = write_data_q;
    if (write_en_d) begin
      write_id_d   = sel_id;
      write_data_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q <= 4'd0;
      write_en_q   <= 1'b0;
      write_id_q   <= 6'd0;
      write_data_q <= 32'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      write_en_q   <= write_en_d;
      write_id_q   <= write_id_d;
      write_data_q <= write_data_d;
    end
  end

  assign write_en   = write_en_q;
  assign write_id   = write_id_q;
  assign write_data = write_data_q;
  assign byp_hit    = write_en_q & (byp_id == write_id_q) & (byp_id != 6'd0);
  assign byp_data   = write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus randomized bench for regfile_write_arbiter against a behavioural model.
module tb_regfile_write_arbiter;

  localparam int L  = 3;
  localparam int RF = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, mem_valid;
  logic [5:0]  alu_id, mem_id, byp_id;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, write_en, byp_hit;
  logic [5:0]  write_id;
  logic [31:0] write_data, byp_data;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.STARVE_LIMIT(L), .REGISTER_FILE_SIZE(RF)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_id(alu_id), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_id(mem_id), .mem_data(mem_data), .mem_ready(mem_ready),
    .write_en(write_en), .write_id(write_id), .write_data(write_data),
    .byp_id(byp_id), .byp_hit(byp_hit), .byp_data(byp_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: cycles MEM has waited, and the last value written to the port.
  int          denied = 0;
  logic        m_en   = 1'b0;
  logic [5:0]  m_id   = 6'd0;
  logic [31:0] m_data = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic cycle(input string tag,
                       input logic av, input logic [5:0] aid, input logic [31:0] ad,
                       input logic mv, input logic [5:0] mid, input logic [31:0] md,
                       input int b1, input int b2,
                       output logic alu_g, output logic mem_g);
    logic [5:0]  gid;
    logic [31:0] gd;
    logic [5:0]  q;
    alu_valid = av; alu_id = aid; alu_data = ad;
    mem_valid = mv; mem_id = mid; mem_data = md;
    #1;
    alu_g = av && (denied != L);
    mem_g = mv && ((denied == L) || !av);
    chk({tag, ".alu_ready"}, alu_ready, alu_g);
    chk({tag, ".mem_ready"}, mem_ready, mem_g);
    @(posedge clk);
    if (mv && !mem_g) denied = (denied < L) ? denied + 1 : L;
    else denied = 0;
    m_en = 1'b0;
    if (alu_g || mem_g) begin
      gid = mem_g ? mid : aid;
      gd  = mem_g ? md  : ad;
      if (gid != 0 && int'(gid) < RF) begin
        m_en = 1'b1; m_id = gid; m_data = gd;
      end
    end
    #1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk({tag, ".write_en"}, write_en, m_en);
    chk({tag, ".write_id"}, write_id, m_id);
    chk({tag, ".write_data"}, write_data, m_data);
    chk({tag, ".byp_data"}, byp_data, m_data);
    q = (b1 < 0) ? m_id : 6'(b1);
    byp_id = q;
    #1;
    chk({tag, ".byp_hit1"}, byp_hit, m_en && q == m_id && q != 0);
    q = (b2 < 0) ? m_id : 6'(b2);
    byp_id = q;
    #1;
    chk({tag, ".byp_hit2"}, byp_hit, m_en && q == m_id && q != 0);
    @(negedge clk);
  endtask

  logic        ag, mg;
  logic        pa_v, pm_v;
  logic [5:0]  pa_id, pm_id;
  logic [31:0] pa_d, pm_d;
  int          wd;

  initial begin
    wd = 0;
    reset_n = 1'b0;
    alu_valid = 1'b1; alu_id = 6'd4; alu_data = 32'hDEAD_BEEF;
    mem_valid = 1'b1; mem_id = 6'd5; mem_data = 32'hCAFE_F00D;
    byp_id = 6'd0;
    #3;
    chk("rst.write_en", write_en, 1'b0);
    chk("rst.write_id", write_id, 6'd0);
    chk("rst.write_data", write_data, 32'd0);
    chk("rst.alu_ready", alu_ready, 1'b0);
    chk("rst.mem_ready", mem_ready, 1'b0);
    chk("rst.byp_hit", byp_hit, 1'b0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    cycle("alu5", 1, 6'd5, 32'h1234_5678, 0, 6'd0, 32'd0, 5, 6, ag, mg);
    chk("alu5.const_data", write_data, 32'h1234_5678);
    cycle("x0", 1, 6'd0, 32'hFFFF_FFFF, 0, 6'd0, 32'd0, 0, 5, ag, mg);
    chk("x0.const_en", write_en, 1'b0);
    cycle("oor", 0, 6'd0, 32'd0, 1, 6'd40, 32'h0BAD_0BAD, 40, 8, ag, mg);
    cycle("idle", 0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 5, 0, ag, mg);
    cycle("byp9", 1, 6'd9, 32'hA5A5_0001, 0, 6'd0, 32'd0, 9, 10, ag, mg);
    chk("byp9.const_data", byp_data, 32'hA5A5_0001);

    cycle("same_a", 1, 6'd3, 32'h11, 1, 6'd3, 32'h22, 3, 2, ag, mg);
    chk("same_a.const_data", write_data, 32'h11);
    cycle("same_m", 0, 6'd0, 32'd0, 1, 6'd3, 32'h22, 3, 0, ag, mg);
    chk("same_m.const_data", write_data, 32'h22);

    // ALU keeps winning until MEM has waited STARVE_LIMIT cycles.
    for (int i = 0; i < 6; i++) begin
      cycle("starve", 1, 6'(10 + i), 32'(100 + i), 1, (i < 4) ? 6'd7 : 6'd8, 32'h77, -1, 7, ag, mg);
      if (i == 3) chk("starve.mem_grant_c4", mg, 1'b1);
      if (i == 4) chk("starve.alu_after", ag, 1'b1);
    end

    // Reset asserted mid-cycle while a write is on the port.
    alu_valid = 1'b1; alu_id = 6'd12; alu_data = 32'h0C0C_0C0C;
    @(posedge clk);
    #2;
    chk("mid.write_en_before", write_en, 1'b1);
    byp_id = 6'd12;
    reset_n = 1'b0;
    #1;
    chk("mid.write_en", write_en, 1'b0);
    chk("mid.write_id", write_id, 6'd0);
    chk("mid.write_data", write_data, 32'd0);
    chk("mid.alu_ready", alu_ready, 1'b0);
    chk("mid.byp_hit", byp_hit, 1'b0);
    @(posedge clk);
    #1;
    chk("mid.lost", write_en, 1'b0);
    alu_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    denied = 0; m_en = 1'b0; m_id = 6'd0; m_data = 32'd0;

    pa_v = 0; pm_v = 0; pa_id = 0; pm_id = 0; pa_d = 0; pm_d = 0;
    for (int n = 0; n < 400; n++) begin
      if (!pa_v && $urandom_range(0, 3) != 0) begin
        pa_v = 1; pa_id = 6'($urandom_range(0, 40)); pa_d = $urandom;
      end
      if (!pm_v && $urandom_range(0, 2) != 0) begin
        pm_v = 1; pm_id = 6'($urandom_range(0, 40)); pm_d = $urandom;
      end
      cycle("rand", pa_v, pa_id, pa_d, pm_v, pm_id, pm_d,
            ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 40)),
            int'($urandom_range(0, 40)), ag, mg);
      if (ag) pa_v = 0;
      if (mg) pm_v = 0;
      if (m_en) wd++;
    end
    chk("rand.some_writes", 32'(wd > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
